// File: rtl/qam_mapper.sv
`timescale 1ns/1ps
`default_nettype none
// qam_mapper: 802.11a constellation mapper. Bytes arrive on a Wishbone slave port.
// One {Im, Re} Q1.15 data subcarrier leaves on a Wishbone master port per 1/2/4/6-bit group.
module qam_mapper (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [7:0]  DAT_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  output logic        ACK_O,
  input  logic [1:0]  MOD_I,
  output logic [31:0] DAT_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I
);

  localparam logic [1:0] MOD_BPSK  = 2'd0;
  localparam logic [1:0] MOD_QPSK  = 2'd1;
  localparam logic [1:0] MOD_QAM16 = 2'd2;
  localparam logic [1:0] MOD_QAM64 = 2'd3;
  localparam logic [5:0] LAST_SYM  = 6'd47;

  logic [15:0] bit_buf;
  logic [4:0]  cnt;
  logic [1:0]  mod_r;
  logic [5:0]  sym_cnt;
  logic        icyc;
  logic        stb_r;
  logic        cyc_r;
  logic [31:0] dat_r;

  logic        rise;
  logic        accept;
  logic        load;
  logic        drop;
  logic [1:0]  mod_eff;
  logic [4:0]  cnt_eff;
  logic [4:0]  nbits;
  logic [15:0] buf_eff;
  logic [15:0] buf_fill;
  logic [31:0] sym;

  function automatic logic [15:0] qpsk_level(input logic b);
    return b ? 16'h5A82 : 16'hA57E;
  endfunction

  // Gray code {earlier bit, later bit} -> -3, -1, +1, +3 in units of 0x2AAA
  function automatic logic [15:0] qam16_level(input logic [1:0] code);
    logic [15:0] v;
    case (code)
      2'b00:   v = 16'h8002;
      2'b01:   v = 16'hD556;
      2'b11:   v = 16'h2AAA;
      default: v = 16'h7FFE;
    endcase
    return v;
  endfunction

  function automatic logic [15:0] qam64_level(input logic [2:0] code);
    logic [15:0] v;
    case (code)
      3'b000:  v = 16'h8001;
      3'b001:  v = 16'hA493;
      3'b011:  v = 16'hC925;
      3'b010:  v = 16'hEDB7;
      3'b110:  v = 16'h1249;
      3'b111:  v = 16'h36DB;
      3'b101:  v = 16'h5B6D;
      default: v = 16'h7FFF;
    endcase
    return v;
  endfunction

  always_comb begin
    rise    = CYC_I & ~icyc;
    // A new packet sees an empty buffer and the mode on MOD_I in the same cycle
    mod_eff = rise ? MOD_I : mod_r;
    cnt_eff = rise ? 5'd0 : cnt;
    buf_eff = rise ? 16'd0 : bit_buf;

    case (mod_eff)
      MOD_BPSK:  nbits = 5'd1;
      MOD_QPSK:  nbits = 5'd2;
      MOD_QAM16: nbits = 5'd4;
      default:   nbits = 5'd6;
    endcase

    accept   = ~RST_I & CYC_I & STB_I & WE_I & (cnt_eff < nbits);
    load     = (cnt_eff >= nbits) & (~stb_r | ACK_I);
    drop     = ~CYC_I & (cnt_eff < nbits) & (~stb_r | ACK_I);
    buf_fill = buf_eff | ({8'd0, DAT_I} << cnt_eff);

    case (mod_eff)
      MOD_BPSK:  sym = {16'h0000, bit_buf[0] ? 16'h7FFF : 16'h8001};
      MOD_QPSK:  sym = {qpsk_level(bit_buf[1]), qpsk_level(bit_buf[0])};
      MOD_QAM16: sym = {qam16_level({bit_buf[2], bit_buf[3]}),
                        qam16_level({bit_buf[0], bit_buf[1]})};
      default:   sym = {qam64_level({bit_buf[3], bit_buf[4], bit_buf[5]}),
                        qam64_level({bit_buf[0], bit_buf[1], bit_buf[2]})};
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      bit_buf <= 16'd0;
      cnt     <= 5'd0;
      mod_r   <= 2'd0;
      sym_cnt <= 6'd0;
      icyc    <= 1'b0;
      stb_r   <= 1'b0;
      cyc_r   <= 1'b0;
      dat_r   <= 32'd0;
    end else begin
      icyc <= CYC_I;

      // The mode may only change between OFDM symbols, once the output is idle
      if (rise || (sym_cnt == 6'd0 && cnt == 5'd0 && !stb_r)) begin
        mod_r <= MOD_I;
      end

      if (rise) begin
        sym_cnt <= 6'd0;
      end else if (load) begin
        sym_cnt <= (sym_cnt == LAST_SYM) ? 6'd0 : sym_cnt + 6'd1;
      end

      if (accept) begin
        bit_buf <= buf_fill;
        cnt     <= cnt_eff + 5'd8;
      end else if (load) begin
        bit_buf <= bit_buf >> nbits;
        cnt     <= cnt - nbits;
      end else if (rise || drop) begin
        bit_buf <= 16'd0;
        cnt     <= 5'd0;
      end

      if (load) begin
        dat_r <= sym;
        stb_r <= 1'b1;
      end else if (stb_r && ACK_I) begin
        stb_r <= 1'b0;
      end

      if (rise) begin
        cyc_r <= 1'b1;
      end else if (drop) begin
        cyc_r <= 1'b0;
      end
    end
  end

  assign ACK_O = accept;
  assign DAT_O = dat_r;
  assign STB_O = stb_r;
  assign WE_O  = stb_r;
  assign CYC_O = cyc_r;

endmodule

`default_nettype wire

// File: tb/tb_qam_mapper.sv
`timescale 1ns/1ps
`default_nettype none
// tb_qam_mapper: directed and randomized checks of qam_mapper against a bit-queue
// reference model that maps symbols with Gray-decode arithmetic.
module tb_qam_mapper;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [7:0]  DAT_I;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic        ACK_O;
  logic [1:0]  MOD_I;
  logic [31:0] DAT_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  wire         ACK_I;

  logic ack_force = 1'b1;
  logic ack_rnd   = 1'b1;
  logic rand_ack  = 1'b0;
  assign ACK_I = rand_ack ? ack_rnd : ack_force;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  bit          bitq[$];
  int          mdl_mode;

  qam_mapper dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I),
    .WE_I(WE_I), .ACK_O(ACK_O), .MOD_I(MOD_I), .DAT_O(DAT_O), .CYC_O(CYC_O),
    .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  always @(posedge CLK_I) begin
    #1;
    ack_rnd = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int nbits(input int mode);
    case (mode)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 6;
    endcase
  endfunction

  // Gray index -> odd level, scaled so the outermost level sits near full scale
  function automatic logic [31:0] ref_map(input int mode, input logic [5:0] b);
    int re, im, idx;
    case (mode)
      0: begin
        re = b[0] ? 32767 : -32767;
        im = 0;
      end
      1: begin
        re = b[0] ? 23170 : -23170;
        im = b[1] ? 23170 : -23170;
      end
      2: begin
        idx = 2 * b[0] + (b[0] ^ b[1]);
        re  = (2 * idx - 3) * 10922;
        idx = 2 * b[2] + (b[2] ^ b[3]);
        im  = (2 * idx - 3) * 10922;
      end
      default: begin
        idx = 4 * b[0] + 2 * (b[0] ^ b[1]) + (b[0] ^ b[1] ^ b[2]);
        re  = (2 * idx - 7) * 4681;
        idx = 4 * b[3] + 2 * (b[3] ^ b[4]) + (b[3] ^ b[4] ^ b[5]);
        im  = (2 * idx - 7) * 4681;
      end
    endcase
    return {im[15:0], re[15:0]};
  endfunction

  task automatic push_model(input logic [7:0] b);
    logic [5:0] v;
    int n;
    for (int i = 0; i < 8; i++) bitq.push_back(b[i]);
    n = nbits(mdl_mode);
    while (bitq.size() >= n) begin
      v = '0;
      for (int i = 0; i < n; i++) v[i] = bitq.pop_front();
      exp_q.push_back(ref_map(mdl_mode, v));
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic wait_ack();
    int t;
    t = 0;
    @(negedge CLK_I);
    while (ACK_O !== 1'b1 && t < 200) begin
      @(negedge CLK_I);
      t++;
    end
    chk1("ack_wait", ACK_O, 1'b1);
    tick();
    STB_I = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit use_model);
    if (use_model) push_model(b);
    DAT_I = b;
    STB_I = 1'b1;
    WE_I  = 1'b1;
    wait_ack();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || STB_O !== 1'b0) && t < 3000) begin
      tick();
      t++;
    end
    tick();
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain observed=%0d_pending expected=0_pending", exp_q.size());
    end
  endtask

  task automatic ofdm_symbol(input int change_at, input logic [1:0] new_mod, input bit gaps);
    int nbytes;
    nbytes = 6 * nbits(mdl_mode);
    for (int k = 0; k < nbytes; k++) begin
      if (k == change_at) MOD_I = new_mod;
      send_byte(8'($urandom), 1'b1);
      if (gaps && $urandom_range(0, 3) == 0) tick();
    end
    drain();
    mdl_mode = int'(MOD_I);
  endtask

  // Output monitor: every handshake consumes one expected symbol; stalls must hold
  logic [31:0] prev_dat = 32'd0;
  bit          prev_stall = 1'b0;
  logic [31:0] exp_v;
  always @(negedge CLK_I) begin
    if (RST_I === 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      chk1("we_o", WE_O, STB_O);
      if (prev_stall) begin
        checks++;
        assert (STB_O === 1'b1 && DAT_O === prev_dat) else begin
          errors++;
          $error("FAIL stall_hold observed=%h/%b expected=%h/1", DAT_O, STB_O, prev_dat);
        end
      end
      if (STB_O === 1'b1 && ACK_I === 1'b1) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL extra_symbol observed=%h expected=none", DAT_O);
        end
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          chk32("symbol", DAT_O, exp_v);
        end
      end
      prev_stall = (STB_O === 1'b1) && (ACK_I !== 1'b1);
      prev_dat   = DAT_O;
    end
  end

  initial begin
    RST_I = 1'b1; CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
    DAT_I = 8'hFF; MOD_I = 2'd0; mdl_mode = 0;
    repeat (3) @(posedge CLK_I);
    @(negedge CLK_I);
    chk1("reset_ack", ACK_O, 1'b0);
    chk1("reset_stb", STB_O, 1'b0);
    chk1("reset_cyc", CYC_O, 1'b0);
    chk32("reset_dat", DAT_O, 32'd0);
    tick();
    RST_I = 1'b0; CYC_I = 1'b0; STB_I = 1'b0;
    tick();

    // BPSK 0xA5 then 0x0F offered immediately: latency and accept spacing
    MOD_I = 2'd0; CYC_I = 1'b1; DAT_I = 8'hA5; STB_I = 1'b1; WE_I = 1'b1;
    exp_q.push_back(32'h00007FFF); exp_q.push_back(32'h00008001);
    exp_q.push_back(32'h00007FFF); exp_q.push_back(32'h00008001);
    exp_q.push_back(32'h00008001); exp_q.push_back(32'h00007FFF);
    exp_q.push_back(32'h00008001); exp_q.push_back(32'h00007FFF);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h00007FFF);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h00008001);
    @(negedge CLK_I);
    chk1("bpsk_ack_first", ACK_O, 1'b1);
    tick();
    DAT_I = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK_I);
      chk1("bpsk_ack_busy", ACK_O, 1'b0);
      if (i == 0) begin
        chk1("bpsk_stb_e0", STB_O, 1'b0);
        chk1("cyc_o_rise", CYC_O, 1'b1);
      end
      if (i == 1) chk1("bpsk_stb_e1", STB_O, 1'b1);
      tick();
    end
    @(negedge CLK_I);
    chk1("bpsk_ack_again", ACK_O, 1'b1);
    tick();
    STB_I = 1'b0; CYC_I = 1'b0;
    drain();
    @(negedge CLK_I);
    chk1("cyc_o_fall", CYC_O, 1'b0);

    // QPSK 0x1B
    tick();
    MOD_I = 2'd1; CYC_I = 1'b1;
    exp_q.push_back(32'h5A825A82); exp_q.push_back(32'h5A82A57E);
    exp_q.push_back(32'hA57E5A82); exp_q.push_back(32'hA57EA57E);
    send_byte(8'h1B, 1'b0);
    CYC_I = 1'b0;
    drain();

    // 16-QAM 0x00
    MOD_I = 2'd2; CYC_I = 1'b1;
    exp_q.push_back(32'h80028002); exp_q.push_back(32'h80028002);
    send_byte(8'h00, 1'b0);
    CYC_I = 1'b0;
    drain();

    // 64-QAM: drop CYC_I with 4 bits left over; they must not leak into the next packet
    MOD_I = 2'd3; mdl_mode = 3; bitq.delete(); CYC_I = 1'b1;
    send_byte(8'hA7, 1'b1);
    send_byte(8'h3C, 1'b1);
    CYC_I = 1'b0;
    drain();
    bitq.delete();
    @(negedge CLK_I);
    chk1("discard_cyc_o", CYC_O, 1'b0);
    tick();
    CYC_I = 1'b1;
    exp_q.push_back(32'hC9257FFF);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h80018001);
    send_byte(8'h31, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    CYC_I = 1'b0;
    drain();

    // Stall: ACK_I low for 5 cycles with a byte on offer
    MOD_I = 2'd1; mdl_mode = 1; bitq.delete(); CYC_I = 1'b1;
    send_byte(8'hC6, 1'b1);
    tick();
    ack_force = 1'b0; DAT_I = 8'h39; STB_I = 1'b1;
    push_model(8'h39);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK_I);
      chk1("stall_ack", ACK_O, 1'b0);
      chk1("stall_stb", STB_O, 1'b1);
      tick();
    end
    ack_force = 1'b1;
    wait_ack();
    CYC_I = 1'b0;
    drain();

    // Mode lock: change to 16-QAM mid-symbol, takes effect only at symbol 48
    MOD_I = 2'd1; mdl_mode = 1; bitq.delete(); CYC_I = 1'b1;
    ofdm_symbol(3, 2'd2, 1'b0);
    ofdm_symbol(99, 2'd2, 1'b0);

    // Randomized data, modes, upstream gaps and downstream stalls
    rand_ack = 1'b1;
    for (int s = 0; s < 4; s++) begin
      ofdm_symbol($urandom_range(2, 5), 2'($urandom_range(0, 3)), 1'b1);
    end
    CYC_I = 1'b0;
    drain();
    rand_ack = 1'b0;
    ack_force = 1'b1;
    @(negedge CLK_I);
    chk1("random_cyc_o", CYC_O, 1'b0);

    // Reset while STB_O is held high by a stall
    tick();
    ack_force = 1'b0; MOD_I = 2'd1; CYC_I = 1'b1;
    send_byte(8'h5A, 1'b0);
    tick();
    @(negedge CLK_I);
    chk1("pre_reset_stb", STB_O, 1'b1);
    tick();
    RST_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
    tick();
    @(negedge CLK_I);
    chk1("rst_stb", STB_O, 1'b0);
    chk1("rst_cyc", CYC_O, 1'b0);
    chk32("rst_dat", DAT_O, 32'd0);
    chk1("rst_ack", ACK_O, 1'b0);
    tick();
    RST_I = 1'b0; STB_I = 1'b0; CYC_I = 1'b0; ack_force = 1'b1;
    exp_q.delete(); bitq.delete();
    tick(); tick();
    @(negedge CLK_I);
    chk1("post_rst_stb", STB_O, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
